// File: rtl/adder_rd32.sv
// adder_rd32
//   32-bit two's-complement adder. The carry-in and carry-out are ASCII status
//   characters ("k" = kill, "g" = generate, "p" = propagate). Carries are
//   resolved by a recursive-doubling (Kogge-Stone style) lookahead network
//   over per-bit kill/generate/propagate states. The result is registered,
//   giving one cycle of latency at full throughput.
//
// Ports
//   clk   : rising-edge clock
//   reset : synchronous, active-high; loads s = 0 and xout = "k"
//   a, b  : 32-bit signed operands
//   xin   : carry-in character; only "g" means carry 1, anything else is 0
//   s     : registered 32-bit sum (wraps, no overflow flag)
//   xout  : registered carry-out of bit 31, "g" or "k"
module adder_rd32 (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [31:0] a,
  input  logic signed [31:0] b,
  input  logic        [7:0]  xin,
  output logic signed [31:0] s,
  output logic        [7:0]  xout
);

  localparam logic [7:0] CHAR_K = 8'h6B;
  localparam logic [7:0] CHAR_G = 8'h67;

  // 2-bit carry-state codes
  localparam logic [1:0] ST_K = 2'b00;
  localparam logic [1:0] ST_P = 2'b01;
  localparam logic [1:0] ST_G = 2'b11;

  localparam int LEVELS = 5;

  // Carry-in node: only "g" generates. "p" and every other code resolve to
  // kill, so an unexpected xin can never leave the chain unresolved.
  logic [1:0] cin_node;
  assign cin_node = (xin == CHAR_G) ? ST_G : ST_K;

  // lvl[0] holds the per-bit states with the carry-in already folded into
  // bit 0. Each later level doubles the span that has been resolved.
  // After the final level, lvl[LEVELS][i] is the carry out of bit i.
  logic [31:0][1:0] lvl [0:LEVELS];

  genvar gi, gl;

  generate
    for (gi = 0; gi < 32; gi++) begin : g_bit_state
      logic [1:0] st;
      always_comb begin
        st = ST_P;
        if (!a[gi] && !b[gi]) st = ST_K;
        else if (a[gi] && b[gi]) st = ST_G;
      end
      if (gi == 0) begin : g_fold_cin
        // Bit 0 combines with the carry-in node at level 0.
        assign lvl[0][gi] = (st == ST_P) ? cin_node : st;
      end else begin : g_plain
        assign lvl[0][gi] = st;
      end
    end

    for (gl = 0; gl < LEVELS; gl++) begin : g_level
      for (gi = 0; gi < 32; gi++) begin : g_node
        if (gi >= (1 << gl)) begin : g_combine
          // A propagating node takes its value from the node 'span' below;
          // a kill or generate node already knows its carry.
          assign lvl[gl+1][gi] = (lvl[gl][gi] == ST_P) ? lvl[gl][gi-(1<<gl)]
                                                       : lvl[gl][gi];
        end else begin : g_pass
          assign lvl[gl+1][gi] = lvl[gl][gi];
        end
      end
    end
  endgenerate

  // Carry into bit i: the carry-in for bit 0, otherwise the resolved carry
  // out of bit i-1. Resolved nodes are k (00) or g (11), so bit 0 of the
  // code is the carry value.
  logic [31:0] carry_in_vec;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_carry
      if (gi == 0) begin : g_c0
        assign carry_in_vec[gi] = cin_node[0];
      end else begin : g_ci
        assign carry_in_vec[gi] = lvl[LEVELS][gi-1][0];
      end
    end
  endgenerate

  logic signed [31:0] s_next;
  logic        [7:0]  xout_next;

  assign s_next    = a ^ b ^ carry_in_vec;
  assign xout_next = lvl[LEVELS][31][0] ? CHAR_G : CHAR_K;

  logic signed [31:0] s_reg;
  logic        [7:0]  xout_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      s_reg    <= '0;
      xout_reg <= CHAR_K;
    end else begin
      s_reg    <= s_next;
      xout_reg <= xout_next;
    end
  end

  assign s    = s_reg;
  assign xout = xout_reg;

endmodule

// File: tb/tb_adder_rd32.sv
module tb_adder_rd32;

  logic               clk;
  logic               reset;
  logic signed [31:0] a;
  logic signed [31:0] b;
  logic        [7:0]  xin;
  logic signed [31:0] s;
  logic        [7:0]  xout;

  int checks = 0;
  int errors = 0;

  adder_rd32 dut (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .b     (b),
    .xin   (xin),
    .s     (s),
    .xout  (xout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [7:0] K = 8'h6B;
  localparam logic [7:0] G = 8'h67;
  localparam logic [7:0] P = 8'h70;

  typedef struct {
    logic        rst;
    logic [31:0] va;
    logic [31:0] vb;
    logic [7:0]  vx;
    logic [31:0] exp_s;
    logic [7:0]  exp_x;
  } vec_t;

  // Reference: plain 33-bit arithmetic, carry-in only for "g".
  function automatic logic [39:0] ref_model(input logic r, input logic [31:0] ra,
                                            input logic [31:0] rb, input logic [7:0] rx);
    logic [32:0] sum;
    if (r) return {K, 32'd0};
    sum = {1'b0, ra} + {1'b0, rb} + {32'd0, (rx == G)};
    return {(sum[32] ? G : K), sum[31:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] exp_s, input logic [7:0] exp_x);
    checks++;
    if (s !== exp_s || xout !== exp_x) begin
      errors++;
      $display("FAIL %s: got s=%08h xout=%02h, expected s=%08h xout=%02h",
               name, s, xout, exp_s, exp_x);
    end
  endtask

  // Drive at the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic r, input logic [31:0] va, input logic [31:0] vb,
                      input logic [7:0] vx);
    @(negedge clk);
    reset = r;
    a     = va;
    b     = vb;
    xin   = vx;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs [13];
  logic [39:0] expv;
  logic [39:0] prev;

  initial begin
    reset = 1'b1;
    a = '0;
    b = '0;
    xin = K;

    vecs[0]  = '{1'b1, 32'd5,        32'd7,        K,     32'd0,        K};
    vecs[1]  = '{1'b0, 32'd5,        32'd7,        K,     32'd12,       K};
    vecs[2]  = '{1'b0, 32'd36865,    32'd33023,    K,     32'd69888,    K};
    vecs[3]  = '{1'b0, 32'd36865,    32'hFFFF7000, K,     32'd1,        G};
    vecs[4]  = '{1'b0, 32'd1,        32'hFFFFFFFE, K,     32'hFFFFFFFF, K};
    vecs[5]  = '{1'b0, 32'hFFFFFFFF, 32'd0,        G,     32'd0,        G};
    vecs[6]  = '{1'b0, 32'hFFFFFFFF, 32'd0,        P,     32'hFFFFFFFF, K};
    vecs[7]  = '{1'b0, 32'd1,        32'd1,        8'h00, 32'd2,        K};
    vecs[8]  = '{1'b0, 32'h80000000, 32'h80000000, K,     32'd0,        G};
    vecs[9]  = '{1'b0, 32'h7FFFFFFF, 32'd1,        K,     32'h80000000, K};
    vecs[10] = '{1'b0, 32'h7FFFFFFF, 32'd0,        G,     32'h80000000, K};
    vecs[11] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, G,     32'd0,        K};
    vecs[12] = '{1'b0, 32'hAAAAAAAA, 32'h55555555, G,     32'd0,        G};

    for (int i = 0; i < 13; i++) begin
      step(vecs[i].rst, vecs[i].va, vecs[i].vb, vecs[i].vx);
      $display("vec %0d: rst=%0b a=%08h b=%08h xin=%02h -> s=%08h xout=%02h",
               i, vecs[i].rst, vecs[i].va, vecs[i].vb, vecs[i].vx, s, xout);
      check($sformatf("vec%0d", i), vecs[i].exp_s, vecs[i].exp_x);
    end

    // Hold: outputs must not change between edges while inputs move.
    step(1'b0, 32'd100, 32'd23, K);
    @(negedge clk);
    a = 32'hDEADBEEF;
    b = 32'h12345678;
    xin = G;
    #2;
    $display("hold: s=%08h xout=%02h", s, xout);
    check("hold", 32'd123, K);

    // Back-to-back random stream with a reset pulse in the middle.
    for (int n = 0; n < 10000; n++) begin
      logic        r;
      logic [31:0] ra;
      logic [31:0] rb;
      logic [7:0]  rx;
      r  = (n == 5000);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 3))
        0:       rx = K;
        1:       rx = G;
        2:       rx = P;
        default: rx = 8'($urandom);
      endcase
      if ($urandom_range(0, 7) == 0) rb = ~ra;   // long propagate chains
      expv = ref_model(r, ra, rb, rx);
      step(r, ra, rb, rx);
      $display("rnd %0d: rst=%0b a=%08h b=%08h xin=%02h -> s=%08h xout=%02h",
               n, r, ra, rb, rx, s, xout);
      check($sformatf("rnd%0d", n), expv[31:0], expv[39:32]);
      prev = expv;
    end

    // Stream resumes cleanly after the final random cycle.
    step(1'b0, 32'd40, 32'd2, G);
    $display("resume: s=%08h xout=%02h", s, xout);
    check("resume", 32'd43, K);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
